// File: rtl/instr_encode_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_isa_pkg
//  Brief    : Instruction-word layout, opcode constants and encode helpers
//             shared by the encoder/issuer and the control-unit decoder.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_isa_pkg;

    localparam int INSTR_W = 16;

    // Field positions inside the 16-bit instruction word
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [3:0]         opcode_t;
    typedef logic [3:0]         reg_t;

    localparam opcode_t OP_ADD = 4'd0;
    localparam opcode_t OP_SUB = 4'd1;
    localparam opcode_t OP_AND = 4'd2;
    localparam opcode_t OP_OR  = 4'd3;
    localparam opcode_t OP_MUL = 4'd4;
    localparam opcode_t OP_DIV = 4'd5;

    // Issue FSM: ISSUE while no bubble is pending, STALL while bubbles count down
    typedef enum logic [0:0] {
        ST_ISSUE = 1'b0,
        ST_STALL = 1'b1
    } issue_state_e;

    // Request op codes 6 and 7 have no ALU operation behind them
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    // Multi-cycle ALU paths need settle bubbles after issue
    function automatic logic is_muldiv(input instr_t w);
        return (w[OPC_MSB:OPC_LSB] == OP_MUL) || (w[OPC_MSB:OPC_LSB] == OP_DIV);
    endfunction

    function automatic instr_t encode_instr(input logic [2:0] op, input reg_t rd,
                                            input reg_t rs1, input reg_t rs2);
        return {1'b0, op, rd, rs1, rs2};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encode_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encode_issue_if
//  Brief    : Request (program source -> issuer) and issue (issuer -> decode)
//             valid/ready channels bundled together.
//  Revision : 1.0  initial release
// ============================================================================
interface instr_encode_issue_if;
    import cpu_isa_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    reg_t       req_rd;
    reg_t       req_rs1;
    reg_t       req_rs2;

    logic       out_valid;
    logic       out_ready;
    instr_t     out_instr;

    // Environment side: produces requests, consumes issued instructions
    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, out_ready,
        input  req_ready, out_valid, out_instr
    );

    // Issuer side
    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, out_ready,
        output req_ready, out_valid, out_instr
    );
endinterface
`default_nettype wire

// File: rtl/instr_encode_issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fifo
//  Brief    : DEPTH x 16 instruction FIFO with registered storage and a
//             combinational head read (zero when empty).
//  Revision : 1.0  initial release
// ============================================================================
module instr_fifo
    import cpu_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  instr_t                   i_din,
    input  logic                     i_pop,
    output instr_t                   o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);

    instr_t            r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_push;
    logic              w_pop;

    // DEPTH is a power of two, so count == DEPTH exactly when the MSB is set
    assign o_full  = r_count[c_AW];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Guard against overflow/underflow regardless of what the caller asks for
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Storage needs no reset: empty-state reads are masked to zero above
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_encode_issue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encode_issue
//  Brief    : Encodes ALU requests into 16-bit instructions, queues them and
//             issues to decode, inserting bubbles after MUL/DIV. Illegal ops
//             are swallowed, flagged and counted.
//  Revision : 1.0  initial release
// ============================================================================
module instr_encode_issue
    import cpu_isa_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int MULDIV_GAP = 2,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_encode_issue_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_illegal,
    output logic [CNT_W-1:0]         illegal_cnt
);

    localparam int                 c_GAP_W    = (MULDIV_GAP > 0) ? $clog2(MULDIV_GAP + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(MULDIV_GAP);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    logic               w_legal;
    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    instr_t             w_word;
    instr_t             w_head;
    issue_state_e       r_state;
    issue_state_e       w_state_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_GAP_W-1:0] w_gap_nxt;
    logic               r_err;
    logic [CNT_W-1:0]   r_illegal_cnt;

    assign w_legal    = is_legal_op(bus.req_op);
    assign w_word     = encode_instr(bus.req_op, bus.req_rd, bus.req_rs1, bus.req_rs2);

    // A full queue refuses requests even when a pop happens the same cycle
    assign bus.req_ready = !w_full;
    assign w_req_fire    = bus.req_valid && !w_full;
    assign w_push        = w_req_fire && w_legal;

    // STALL is held exactly while the bubble counter is non-zero
    assign bus.out_valid = !w_empty && (r_state == ST_ISSUE);
    assign bus.out_instr = w_head;
    assign w_pop         = bus.out_valid && bus.out_ready;

    assign err_illegal = r_err;
    assign illegal_cnt = r_illegal_cnt;

    instr_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_din   (w_word),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    // Next-state: load bubbles on a MUL/DIV issue, count them down while stalled
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            ST_ISSUE: begin
                if (w_pop && is_muldiv(w_head) && (MULDIV_GAP != 0)) begin
                    w_gap_nxt   = c_GAP_LOAD;
                    w_state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                w_gap_nxt = r_gap_cnt - c_GAP_W'(1);
                if (r_gap_cnt == c_GAP_W'(1)) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: begin
                w_state_nxt = ST_ISSUE;
                w_gap_nxt   = '0;
            end
        endcase
    end

    // Issue FSM state and bubble counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_ISSUE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    // Illegal-op pulse and saturating illegal-request counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err         <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_err <= w_req_fire && !w_legal;
            if (w_req_fire && !w_legal && (r_illegal_cnt != c_CNT_MAX)) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encode_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encode_issue
//  Brief    : Directed self-checking bench for instr_encode_issue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_encode_issue;
    import cpu_isa_pkg::*;

    localparam int DEPTH      = 4;
    localparam int MULDIV_GAP = 2;
    localparam int CNT_W      = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       count;
    logic             err_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int total = 0;
    int bad   = 0;

    instr_encode_issue_if bus_if ();

    instr_encode_issue #(
        .DEPTH       (DEPTH),
        .MULDIV_GAP  (MULDIV_GAP),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .count       (count),
        .err_illegal (err_illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2);
        bus_if.req_valid = v;
        bus_if.req_op    = op;
        bus_if.req_rd    = rd;
        bus_if.req_rs1   = rs1;
        bus_if.req_rs2   = rs2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    instr_t     q[$];
    instr_t     w;
    int         pushed;
    int         popped;
    int         mgap;
    logic       v;
    logic       exp_valid;
    logic       full_m;
    logic [2:0] op;
    logic [3:0] rd, rs1, rs2;

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        bus_if.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(bus_if.out_valid), 0);
        chk("rst_instr", 32'(bus_if.out_instr), 0);
        chk("rst_err", 32'(err_illegal), 0);
        chk("rst_icnt", 32'(illegal_cnt), 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(bus_if.req_ready), 1);

        // ---------------- encode ----------------
        tick();
        bus_if.out_ready = 1'b1;
        drive(1'b1, 3'd0, 4'h1, 4'h2, 4'h3);
        tick();
        chk("enc_valid0", 32'(bus_if.out_valid), 1);
        chk("enc_add", 32'(bus_if.out_instr), 32'h0123);
        drive(1'b1, 3'd3, 4'hF, 4'hE, 4'hD);
        tick();
        chk("enc_or", 32'(bus_if.out_instr), 32'h3FED);
        chk("enc_count", 32'(count), 1);
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("enc_empty_valid", 32'(bus_if.out_valid), 0);
        chk("enc_empty_instr", 32'(bus_if.out_instr), 0);

        // ---------------- full ----------------
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd0, 4'(i + 1), 4'd0, 4'd0);
            #1;
            chk("full_ready", 32'(bus_if.req_ready), (i < 4) ? 1 : 0);
            tick();
        end
        drive(1'b1, 3'd1, 4'h7, 4'h7, 4'h7);
        bus_if.out_ready = 1'b1;
        #1;
        chk("full_count", 32'(count), 4);
        chk("full_ready_lo", 32'(bus_if.req_ready), 0);
        chk("full_head", 32'(bus_if.out_instr), 32'h0100);
        tick();
        chk("full_poponly_count", 32'(count), 3);
        chk("full_head2", 32'(bus_if.out_instr), 32'h0200);
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("full_head3", 32'(bus_if.out_instr), 32'h0300);
        tick();
        chk("full_head4", 32'(bus_if.out_instr), 32'h0400);
        tick();
        chk("full_drained", 32'(count), 0);
        chk("full_drained_valid", 32'(bus_if.out_valid), 0);

        // ---------------- illegal ----------------
        bus_if.out_ready = 1'b0;
        drive(1'b1, 3'd6, 4'h1, 4'h1, 4'h1);
        #1;
        chk("ill_ready", 32'(bus_if.req_ready), 1);
        chk("ill_err_pre", 32'(err_illegal), 0);
        tick();
        chk("ill_err", 32'(err_illegal), 1);
        chk("ill_cnt1", 32'(illegal_cnt), 1);
        chk("ill_noqueue", 32'(count), 0);
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("ill_err_pulse", 32'(err_illegal), 0);
        drive(1'b1, 3'd7, 4'h2, 4'h2, 4'h2);
        for (int i = 0; i < 300; i++) tick();
        chk("ill_sat", 32'(illegal_cnt), 255);
        chk("ill_sat_noqueue", 32'(count), 0);
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("ill_sat_hold", 32'(illegal_cnt), 255);
        chk("ill_err_end", 32'(err_illegal), 0);

        // ---------------- MUL/DIV gap ----------------
        drive(1'b1, 3'd4, 4'h1, 4'h2, 4'h3);
        tick();
        drive(1'b1, 3'd0, 4'h4, 4'h5, 4'h6);
        tick();
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        chk("gap_count", 32'(count), 2);
        chk("gap_mul", 32'(bus_if.out_instr), 32'h4123);
        chk("gap_valid_pre", 32'(bus_if.out_valid), 1);
        bus_if.out_ready = 1'b1;
        tick();
        chk("gap_bubble1", 32'(bus_if.out_valid), 0);
        chk("gap_bubble1_count", 32'(count), 1);
        tick();
        chk("gap_bubble2", 32'(bus_if.out_valid), 0);
        chk("gap_bubble2_count", 32'(count), 1);
        tick();
        chk("gap_resume", 32'(bus_if.out_valid), 1);
        chk("gap_add", 32'(bus_if.out_instr), 32'h0456);
        tick();
        chk("gap_drained", 32'(count), 0);
        bus_if.out_ready = 1'b0;

        // ---------------- async reset mid-stream ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd2, 4'(i + 1), 4'h9, 4'h9);
            tick();
        end
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        chk("mrst_pre_count", 32'(count), 3);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_count", 32'(count), 0);
        chk("mrst_valid", 32'(bus_if.out_valid), 0);
        chk("mrst_instr", 32'(bus_if.out_instr), 0);
        chk("mrst_icnt", 32'(illegal_cnt), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("mrst_ready", 32'(bus_if.req_ready), 1);
        chk("mrst_count_after", 32'(count), 0);

        // ---------------- random stream vs reference queue ----------------
        pushed = 0;
        popped = 0;
        mgap   = 0;
        for (int cyc = 0; cyc < 600 && (pushed < 20 || q.size() != 0); cyc++) begin
            v   = (pushed < 20) && ($urandom_range(0, 3) != 0);
            op  = 3'($urandom_range(0, 5));
            rd  = 4'($urandom_range(0, 15));
            rs1 = 4'($urandom_range(0, 15));
            rs2 = 4'($urandom_range(0, 15));
            drive(v, op, rd, rs1, rs2);
            bus_if.out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_valid = (q.size() != 0) && (mgap == 0);
            full_m    = (q.size() == DEPTH);
            chk("rnd_ready", 32'(bus_if.req_ready), full_m ? 0 : 1);
            chk("rnd_valid", 32'(bus_if.out_valid), exp_valid ? 1 : 0);
            chk("rnd_count", 32'(count), 32'(q.size()));
            if (exp_valid) chk("rnd_instr", 32'(bus_if.out_instr), 32'(q[0]));
            if (exp_valid && bus_if.out_ready) begin
                w = q.pop_front();
                popped++;
                mgap = (w[15:12] == 4'd4 || w[15:12] == 4'd5) ? MULDIV_GAP : 0;
            end else if (mgap > 0) begin
                mgap--;
            end
            if (v && !full_m) begin
                q.push_back({1'b0, op, rd, rs1, rs2});
                pushed++;
            end
            tick();
        end
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
        chk("rnd_pushed", 32'(pushed), 20);
        chk("rnd_popped", 32'(popped), 20);
        chk("rnd_final_count", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
